// File: rtl/tx_pkt_arbiter.sv
// Purpose: packet-granular round-robin arbiter sharing the pkt_tx_* write port between two sources.
// Latency: 1 cycle from accept to pkt_tx_*; a new grant costs 1 cycle from IDLE, 0 cycles on an eop handoff.
// Backpressure: pkt_tx_full stalls the granted source and holds the grant; the non-granted source always sees full.
//
// Ports:
//   clk_156m25, reset_156m25_n      clock, asynchronous active-low reset
//   pkt0_tx_*, pkt1_tx_*            source word interfaces (data/val/sop/eop/mod in, full out)
//   pkt_tx_*                        registered merged word stream to tx_enqueue, pkt_tx_full back
//   status_grant                    one-hot current grant (00 = idle)
//   status_pkt0_cnt/status_pkt1_cnt wrapping count of packets forwarded per source
//   status_proto_err_tog            toggles on every accepted mid-packet sop word
module tx_pkt_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,

  input  logic [63:0]      pkt0_tx_data,
  input  logic             pkt0_tx_val,
  input  logic             pkt0_tx_sop,
  input  logic             pkt0_tx_eop,
  input  logic [2:0]       pkt0_tx_mod,
  output logic             pkt0_tx_full,

  input  logic [63:0]      pkt1_tx_data,
  input  logic             pkt1_tx_val,
  input  logic             pkt1_tx_sop,
  input  logic             pkt1_tx_eop,
  input  logic [2:0]       pkt1_tx_mod,
  output logic             pkt1_tx_full,

  output logic [63:0]      pkt_tx_data,
  output logic             pkt_tx_val,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic [2:0]       pkt_tx_mod,
  input  logic             pkt_tx_full,

  output logic [1:0]       status_grant,
  output logic [CNT_W-1:0] status_pkt0_cnt,
  output logic [CNT_W-1:0] status_pkt1_cnt,
  output logic             status_proto_err_tog
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;  // index of the source granted most recently
  logic   first_word;                  // next accepted word is the first of the granted packet

  logic req0, req1;
  logic acc0, acc1;
  logic new_grant;
  logic proto_err;

  assign req0 = pkt0_tx_val & pkt0_tx_sop;
  assign req1 = pkt1_tx_val & pkt1_tx_sop;

  assign acc0 = (state == GNT0) & pkt0_tx_val & ~pkt_tx_full;
  assign acc1 = (state == GNT1) & pkt1_tx_val & ~pkt_tx_full;

  assign pkt0_tx_full = pkt_tx_full | (state != GNT0);
  assign pkt1_tx_full = pkt_tx_full | (state != GNT1);

  assign status_grant = {state == GNT1, state == GNT0};

  // Grant changes only at packet boundaries. On an eop handoff the other
  // source is granted directly; the finishing source cannot be regranted
  // because its following sop word is not presented until next cycle.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_grant)) begin
          state_nxt      = GNT0;
          last_grant_nxt = 1'b0;
        end else if (req1) begin
          state_nxt      = GNT1;
          last_grant_nxt = 1'b1;
        end
      end
      GNT0: begin
        if (acc0 && pkt0_tx_eop) begin
          if (req1) begin
            state_nxt      = GNT1;
            last_grant_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GNT1: begin
        if (acc1 && pkt1_tx_eop) begin
          if (req0) begin
            state_nxt      = GNT0;
            last_grant_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign new_grant = (state_nxt != state) && (state_nxt != IDLE);

  // A sop on any accepted word other than the first of the packet is a
  // source protocol violation; the word still goes through untouched.
  assign proto_err = ((acc0 & pkt0_tx_sop) | (acc1 & pkt1_tx_sop)) & ~first_word;

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      first_word <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (new_grant) begin
        first_word <= 1'b1;
      end else if (acc0 || acc1) begin
        first_word <= 1'b0;
      end
    end
  end

  // Output register: idle cycles are driven fully to zero.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      pkt_tx_val  <= 1'b0;
      pkt_tx_data <= 64'd0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= 3'd0;
    end else if (acc0) begin
      pkt_tx_val  <= 1'b1;
      pkt_tx_data <= pkt0_tx_data;
      pkt_tx_sop  <= pkt0_tx_sop;
      pkt_tx_eop  <= pkt0_tx_eop;
      pkt_tx_mod  <= pkt0_tx_eop ? pkt0_tx_mod : 3'd0;
    end else if (acc1) begin
      pkt_tx_val  <= 1'b1;
      pkt_tx_data <= pkt1_tx_data;
      pkt_tx_sop  <= pkt1_tx_sop;
      pkt_tx_eop  <= pkt1_tx_eop;
      pkt_tx_mod  <= pkt1_tx_eop ? pkt1_tx_mod : 3'd0;
    end else begin
      pkt_tx_val  <= 1'b0;
      pkt_tx_data <= 64'd0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= 3'd0;
    end
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      status_pkt0_cnt      <= '0;
      status_pkt1_cnt      <= '0;
      status_proto_err_tog <= 1'b0;
    end else begin
      if (acc0 && pkt0_tx_eop) begin
        status_pkt0_cnt <= status_pkt0_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (acc1 && pkt1_tx_eop) begin
        status_pkt1_cnt <= status_pkt1_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (proto_err) begin
        status_proto_err_tog <= ~status_proto_err_tog;
      end
    end
  end

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Purpose: self-checking bench for tx_pkt_arbiter against a packet-level reference model.
// Latency: model predicts each output word 1 cycle after its accept edge.
// Backpressure: sources advance on the model's own full, so the DUT is checked, never trusted.
module tb_tx_pkt_arbiter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [63:0]      pkt0_tx_data, pkt1_tx_data, pkt_tx_data;
  logic             pkt0_tx_val, pkt0_tx_sop, pkt0_tx_eop, pkt0_tx_full;
  logic             pkt1_tx_val, pkt1_tx_sop, pkt1_tx_eop, pkt1_tx_full;
  logic [2:0]       pkt0_tx_mod, pkt1_tx_mod, pkt_tx_mod;
  logic             pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_full;
  logic [1:0]       status_grant;
  logic [CNT_W-1:0] status_pkt0_cnt, status_pkt1_cnt;
  logic             status_proto_err_tog;

  tx_pkt_arbiter #(.CNT_W(CNT_W)) dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .pkt0_tx_data(pkt0_tx_data), .pkt0_tx_val(pkt0_tx_val), .pkt0_tx_sop(pkt0_tx_sop),
    .pkt0_tx_eop(pkt0_tx_eop), .pkt0_tx_mod(pkt0_tx_mod), .pkt0_tx_full(pkt0_tx_full),
    .pkt1_tx_data(pkt1_tx_data), .pkt1_tx_val(pkt1_tx_val), .pkt1_tx_sop(pkt1_tx_sop),
    .pkt1_tx_eop(pkt1_tx_eop), .pkt1_tx_mod(pkt1_tx_mod), .pkt1_tx_full(pkt1_tx_full),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_full(pkt_tx_full),
    .status_grant(status_grant), .status_pkt0_cnt(status_pkt0_cnt),
    .status_pkt1_cnt(status_pkt1_cnt), .status_proto_err_tog(status_proto_err_tog)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } word_t;

  word_t q0[$];
  word_t q1[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state: who owns the output port, who won last, etc.
  int    owner;      // -1 idle, else source index
  int    last_src;
  bit    first;
  bit    e_val;
  word_t e_out;
  int    m_cnt0, m_cnt1;
  bit    m_tog;

  int    cyc = 0;
  word_t out_log[$];
  int    out_cyc[$];
  int    sop_src[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    owner    = -1;
    last_src = 1;
    first    = 1'b0;
    e_val    = 1'b0;
    e_out    = '0;
    m_cnt0   = 0;
    m_cnt1   = 0;
    m_tog    = 1'b0;
  endtask

  task automatic drive_inputs();
    word_t w0, w1;
    w0 = (q0.size() > 0) ? q0[0] : '0;
    w1 = (q1.size() > 0) ? q1[0] : '0;
    pkt0_tx_val  = (q0.size() > 0);
    pkt0_tx_data = w0.data;
    pkt0_tx_sop  = w0.sop;
    pkt0_tx_eop  = w0.eop;
    pkt0_tx_mod  = w0.mod;
    pkt1_tx_val  = (q1.size() > 0);
    pkt1_tx_data = w1.data;
    pkt1_tx_sop  = w1.sop;
    pkt1_tx_eop  = w1.eop;
    pkt1_tx_mod  = w1.mod;
  endtask

  // Word data: {source, packet id, 16'hC0DE, word index}.
  task automatic add_pkt(input int s, input int p, input int n, input int m, input int err_idx);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.data = {8'(s), 8'(p), 16'hC0DE, 32'(i)};
      w.sop  = (i == 0) || (i == err_idx);
      w.eop  = (i == n - 1);
      w.mod  = (i == n - 1) ? 3'(m) : 3'd0;
      if (s == 0) q0.push_back(w);
      else        q1.push_back(w);
    end
    drive_inputs();
  endtask

  task automatic clear_log();
    out_log.delete();
    out_cyc.delete();
    sop_src.delete();
  endtask

  // One clock: advance the model on the edge, refresh sources, then compare on the negedge.
  task automatic step();
    bit    v0, v1, a0, a1, r0, r1;
    word_t w0, w1, wa;
    int    oth;
    @(posedge clk);
    v0 = q0.size() > 0;
    v1 = q1.size() > 0;
    w0 = v0 ? q0[0] : '0;
    w1 = v1 ? q1[0] : '0;
    a0 = (owner == 0) && v0 && !pkt_tx_full;
    a1 = (owner == 1) && v1 && !pkt_tx_full;
    r0 = v0 && w0.sop;
    r1 = v1 && w1.sop;
    e_val = a0 || a1;
    wa = a0 ? w0 : (a1 ? w1 : '0);
    if (!wa.eop) wa.mod = 3'd0;
    e_out = wa;
    if (a0 && w0.eop) m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W);
    if (a1 && w1.eop) m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W);
    if (((a0 && w0.sop) || (a1 && w1.sop)) && !first) m_tog = !m_tog;
    if (a0 || a1) first = 1'b0;
    if (owner < 0) begin
      if (r0 && r1)  owner = 1 - last_src;
      else if (r0)   owner = 0;
      else if (r1)   owner = 1;
      if (owner >= 0) begin
        last_src = owner;
        first    = 1'b1;
      end
    end else if ((a0 && w0.eop) || (a1 && w1.eop)) begin
      oth = 1 - owner;
      if ((oth == 0 && r0) || (oth == 1 && r1)) begin
        owner    = oth;
        last_src = oth;
        first    = 1'b1;
      end else begin
        owner = -1;
      end
    end
    if (a0) w0 = q0.pop_front();
    if (a1) w1 = q1.pop_front();
    #1;
    drive_inputs();
    cyc++;
    @(negedge clk);
    chk("pkt_tx_val",  {63'd0, pkt_tx_val}, {63'd0, e_val});
    chk("pkt_tx_data", pkt_tx_data, e_out.data);
    chk("pkt_tx_sop",  {63'd0, pkt_tx_sop}, {63'd0, e_out.sop});
    chk("pkt_tx_eop",  {63'd0, pkt_tx_eop}, {63'd0, e_out.eop});
    chk("pkt_tx_mod",  {61'd0, pkt_tx_mod}, {61'd0, e_out.mod});
    chk("status_grant", {62'd0, status_grant},
        (owner == 0) ? 64'd1 : ((owner == 1) ? 64'd2 : 64'd0));
    chk("pkt0_tx_full", {63'd0, pkt0_tx_full}, {63'd0, (pkt_tx_full || owner != 0)});
    chk("pkt1_tx_full", {63'd0, pkt1_tx_full}, {63'd0, (pkt_tx_full || owner != 1)});
    chk("status_pkt0_cnt", {48'd0, status_pkt0_cnt}, 64'(m_cnt0));
    chk("status_pkt1_cnt", {48'd0, status_pkt1_cnt}, 64'(m_cnt1));
    chk("status_proto_err_tog", {63'd0, status_proto_err_tog}, {63'd0, m_tog});
    if (pkt_tx_val) begin
      out_log.push_back({pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod});
      out_cyc.push_back(cyc);
      if (pkt_tx_sop) sop_src.push_back(int'(pkt_tx_data[63:56]));
    end
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || owner >= 0 || e_val) && n < max) begin
      step();
      n++;
    end
    if (n >= max) begin
      checks++;
      failures++;
      $display("FAIL run_bound: still busy after %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    drive_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int start, i_eop, i_sop, n, k;
    rst_n       = 1'b0;
    pkt_tx_full = 1'b0;
    model_reset();
    drive_inputs();
    repeat (3) @(negedge clk);
    chk("reset_val",   {63'd0, pkt_tx_val}, 64'd0);
    chk("reset_data",  pkt_tx_data, 64'd0);
    chk("reset_grant", {62'd0, status_grant}, 64'd0);
    chk("reset_cnt0",  {48'd0, status_pkt0_cnt}, 64'd0);
    chk("reset_tog",   {63'd0, status_proto_err_tog}, 64'd0);
    chk("reset_full0", {63'd0, pkt0_tx_full}, 64'd1);
    rst_n = 1'b1;

    // Single source, 4 words, mod 3 on the last word.
    clear_log();
    start = cyc;
    add_pkt(0, 1, 4, 3, -1);
    run_until_idle(50);
    chk("t1_words", 64'(out_log.size()), 64'd4);
    if (out_log.size() == 4) begin
      chk("t1_first_cycle", 64'(out_cyc[0] - start), 64'd2);
      chk("t1_last_cycle",  64'(out_cyc[3] - start), 64'd5);
      chk("t1_sop_w0", {63'd0, out_log[0].sop}, 64'd1);
      chk("t1_sop_w1", {63'd0, out_log[1].sop}, 64'd0);
      chk("t1_eop_w3", {63'd0, out_log[3].eop}, 64'd1);
      chk("t1_mod_w3", {61'd0, out_log[3].mod}, 64'd3);
    end
    chk("t1_cnt0",  {48'd0, status_pkt0_cnt}, 64'd1);
    chk("t1_idle",  {62'd0, status_grant}, 64'd0);

    // Tie after reset: three 2-word packets queued on each source.
    do_reset();
    clear_log();
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, 10 + p, 2, 0, -1);
      add_pkt(1, 20 + p, 2, 5, -1);
    end
    run_until_idle(100);
    chk("tie_pkts", 64'(sop_src.size()), 64'd6);
    if (sop_src.size() == 6) begin
      for (int j = 0; j < 6; j++) chk("tie_order", 64'(sop_src[j]), 64'(j % 2));
    end
    chk("tie_words", 64'(out_log.size()), 64'd12);
    if (out_log.size() == 12) chk("tie_contiguous", 64'(out_cyc[11] - out_cyc[0]), 64'd11);
    chk("tie_cnt0", {48'd0, status_pkt0_cnt}, 64'd3);
    chk("tie_cnt1", {48'd0, status_pkt1_cnt}, 64'd3);

    // Back-to-back handoff: source 1 requests while source 0 is mid-packet.
    clear_log();
    add_pkt(0, 30, 4, 1, -1);
    step();
    add_pkt(1, 31, 3, 2, -1);
    run_until_idle(50);
    i_eop = -1;
    i_sop = -1;
    foreach (out_log[j]) begin
      if (out_log[j].data[63:48] == 16'h001E && out_log[j].eop) i_eop = j;
      if (out_log[j].data[63:48] == 16'h011F && out_log[j].sop) i_sop = j;
    end
    chk("b2b_found", 64'((i_eop >= 0) && (i_sop >= 0)), 64'd1);
    if (i_eop >= 0 && i_sop >= 0) chk("b2b_gap", 64'(out_cyc[i_sop] - out_cyc[i_eop]), 64'd1);

    // Backpressure for 5 cycles while word 3 of 6 is pending.
    clear_log();
    add_pkt(0, 5, 6, 7, -1);
    k = 0;
    while (q0.size() > 4 && k < 20) begin
      step();
      k++;
    end
    chk("bp_reached_w3", 64'(q0.size()), 64'd4);
    pkt_tx_full = 1'b1;
    repeat (5) begin
      step();
      chk("bp_val",   {63'd0, pkt_tx_val}, 64'd0);
      chk("bp_full0", {63'd0, pkt0_tx_full}, 64'd1);
      chk("bp_grant", {62'd0, status_grant}, 64'd1);
    end
    pkt_tx_full = 1'b0;
    run_until_idle(50);
    n = 0;
    foreach (out_log[j]) begin
      if (out_log[j].data[55:48] == 8'd5) begin
        chk("bp_order", {32'd0, out_log[j].data[31:0]}, 64'(n));
        n++;
      end
    end
    chk("bp_count", 64'(n), 64'd6);

    // Protocol error: sop repeated on word 2 of a 4-word packet.
    do_reset();
    clear_log();
    add_pkt(0, 7, 4, 0, 1);
    run_until_idle(50);
    chk("perr_words", 64'(out_log.size()), 64'd4);
    if (out_log.size() == 4) chk("perr_fwd_sop", {63'd0, out_log[1].sop}, 64'd1);
    chk("perr_tog",  {63'd0, status_proto_err_tog}, 64'd1);
    chk("perr_cnt0", {48'd0, status_pkt0_cnt}, 64'd1);

    // Asynchronous reset in the middle of a 5-word packet.
    clear_log();
    add_pkt(0, 9, 5, 2, -1);
    k = 0;
    while (q0.size() > 3 && k < 20) begin
      step();
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_val",   {63'd0, pkt_tx_val}, 64'd0);
    chk("rst_data",  pkt_tx_data, 64'd0);
    chk("rst_grant", {62'd0, status_grant}, 64'd0);
    chk("rst_cnt0",  {48'd0, status_pkt0_cnt}, 64'd0);
    chk("rst_tog",   {63'd0, status_proto_err_tog}, 64'd0);
    q0.delete();
    q1.delete();
    model_reset();
    drive_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    add_pkt(1, 11, 2, 1, -1);
    step();
    chk("rst_regrant1", {62'd0, status_grant}, 64'd2);
    run_until_idle(50);
    chk("rst_cnt1", {48'd0, status_pkt1_cnt}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
